counter_hour: RTL
=================

# counter_hour

Hour stage of the digital clock chain, directly downstream of the minute counter. It consumes the minute counter's `carry_min` level and advances a 0–23 hour count once per carry rising edge. It also supports button-driven manual setting, a 12/24-hour display view with a PM flag, and a one-cycle end-of-day pulse. It shares the minute-domain clock and reset.

## Interface
Parameters:
- `HOUR_WRAP`, default 23: last hour value; the count wraps from `HOUR_WRAP` to 0.

Ports:
- `clock`  in  1  divided system clock (~2.98 Hz), shared with the minute and second counters
- `reset_min`  in  1  reset: asynchronous, active-high; clock `clock`
- `carry_min`  in  1  minute-counter carry level; each 0→1 transition requests hour +1
- `load_hour`  in  1  setting mode; high blocks normal counting
- `setting_hour`  in  1  set button; each 0→1 transition while `load_hour`=1 requests hour +1
- `mode_12h`  in  1  display view select: 1 = 12-hour, 0 = 24-hour
- `count_hour`  out  5  registered hour, 0..`HOUR_WRAP`
- `disp_hour`  out  5  display hour (combinational from `count_hour` and `mode_12h`)
- `pm`  out  1  1 when `count_hour` ≥ 12 (combinational)
- `carry_day`  out  1  registered one-cycle pulse when the count wraps in normal mode

## Operation
Internal registers:
- `cm_q`: previous `carry_min`; resets to 0; updated every cycle.
- `set_q`: previous `setting_hour`; resets to 0; updated every cycle.
- Both registers update every cycle regardless of mode.

Event decode:
- `inc_evt` = `carry_min` & ~`cm_q`.
- `set_evt` = `setting_hour` & ~`set_q` & `load_hour`.

Priority per clock edge:
1. **Reset:** `count_hour`=0, `carry_day`=0, `cm_q`=0, `set_q`=0.
2. **Setting mode (`load_hour`=1):**
   - On `set_evt`, `count_hour` +1; `HOUR_WRAP` wraps to 0.
   - `carry_day` stays 0 in this mode, including on wrap.
   - `inc_evt` is discarded, not deferred.
3. **Normal mode (`load_hour`=0):**
   - On `inc_evt` with `count_hour` < `HOUR_WRAP`: +1, `carry_day`=0.
   - On `inc_evt` with `count_hour` = `HOUR_WRAP`: `count_hour`=0, `carry_day`=1.
4. **Otherwise:** hold `count_hour`; `carry_day`=0.

Rules:
- A held-high `carry_min` or `setting_hour` produces exactly one event.
- `carry_min` already high when `load_hour` falls produces no event, because `cm_q` is already 1.
- `count_hour` is 5-bit unsigned. Values above `HOUR_WRAP` are unreachable; if forced, the next increment event loads 0.

Display mapping:
- `mode_12h`=0: `disp_hour` = `count_hour`.
- `mode_12h`=1: 0→12, 1..12 unchanged, 13..23 → `count_hour`−12.
- `pm` is independent of `mode_12h`.

## Timing
- Reset values: `count_hour`=0, `carry_day`=0, `pm`=0, `disp_hour`=0 (24h) or 12 (12h).
- `carry_min` rising between edges k−1 and k: `count_hour` updates at edge k. No extra latency beyond the sampling edge; `cm_q` captures 1 at the same edge.
- `carry_day` is high for exactly the one cycle following the wrap edge, together with `count_hour`=0.
- Same-edge `inc_evt` and `set_evt`: only `set_evt` acts, since setting mode has priority.
- Reset asserted mid-count clears everything immediately. `carry_min` is 0 out of reset because the minute counter shares `reset_min`, so no spurious event occurs.
- `mode_12h` changes affect `disp_hour` combinationally, with no effect on `count_hour`.

## Test plan
- **Reset mid-count:** reset at `count_hour`=7 → `count_hour`=0, `carry_day`=0, `pm`=0 immediately.
- **Held carry:** `carry_min` pulses 0→1 held 3 cycles, repeated 13 times from 0 → `count_hour`=13, `pm`=1, `disp_hour`=1 with `mode_12h`=1 and 13 with `mode_12h`=0.
- **End-of-day wrap:** `count_hour`=23, one `carry_min` rise → `count_hour`=0, `carry_day` high exactly 1 cycle, `disp_hour`=12 in 12h mode.
- **Setting mode:** `load_hour`=1, `setting_hour` held high 5 cycles, then 2 more presses from 22 → 23, 0, 1; `carry_day` never asserts.
- **Carry during setting:** `carry_min` rises while `load_hour`=1, then `load_hour` drops with `carry_min` still 1 → `count_hour` unchanged.
- **Simultaneous events:** `carry_min` and `setting_hour` rise on the same edge with `load_hour`=1 at count 4 → `count_hour`=5, not 6.

Source files
------------

// File: rtl/counter_hour.sv
// Hour stage of the clock chain: counts minute carries 0..HOUR_WRAP,
// supports button setting, 12/24h display view and an end-of-day pulse.
module counter_hour #(
  parameter int unsigned HOUR_WRAP = 23
) (
  input  logic       clock,
  input  logic       reset_min,
  input  logic       carry_min,
  input  logic       load_hour,
  input  logic       setting_hour,
  input  logic       mode_12h,
  output logic [4:0] count_hour,
  output logic [4:0] disp_hour,
  output logic       pm,
  output logic       carry_day
);

  localparam logic [4:0] LP_WRAP = 5'(HOUR_WRAP);

  logic       r_cm_q;
  logic       r_set_q;
  logic [4:0] r_count;
  logic       r_carry;

  logic       w_inc_evt;
  logic       w_set_evt;
  logic       w_at_wrap;
  logic [4:0] w_count_inc;
  logic [4:0] w_count_nxt;
  logic       w_carry_nxt;
  logic [4:0] w_disp;

  assign w_inc_evt = carry_min & ~r_cm_q;
  assign w_set_evt = setting_hour & ~r_set_q & load_hour;

  // Out-of-range values (only reachable if forced) fold back to 0.
  assign w_at_wrap   = (r_count >= LP_WRAP);
  assign w_count_inc = w_at_wrap ? 5'd0 : r_count + 5'd1;

  always_comb begin
    w_count_nxt = r_count;
    w_carry_nxt = 1'b0;
    if (load_hour) begin
      if (w_set_evt) begin
        w_count_nxt = w_count_inc;
      end
    end else if (w_inc_evt) begin
      w_count_nxt = w_count_inc;
      w_carry_nxt = w_at_wrap;
    end
  end

  always_ff @(posedge clock or posedge reset_min) begin
    if (reset_min) begin
      r_cm_q  <= 1'b0;
      r_set_q <= 1'b0;
      r_count <= 5'd0;
      r_carry <= 1'b0;
    end else begin
      r_cm_q  <= carry_min;
      r_set_q <= setting_hour;
      r_count <= w_count_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  always_comb begin
    w_disp = r_count;
    if (mode_12h) begin
      if (r_count == 5'd0) begin
        w_disp = 5'd12;
      end else if (r_count > 5'd12) begin
        w_disp = r_count - 5'd12;
      end
    end
  end

  assign count_hour = r_count;
  assign carry_day  = r_carry;
  assign disp_hour  = w_disp;
  assign pm         = (r_count >= 5'd12);

endmodule
